// File: rtl/z80_dma_arbiter_if.sv
// Bundle of the DMA control, CPU bus-request handshake and memory bus signals.
// master = DMA engine side, slave = system/testbench side.
interface z80_dma_arbiter_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [15:0]      src_addr;
  logic [15:0]      dst_addr;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             done;
  logic             cpu_busrq_n;
  logic             cpu_busak_n;
  logic             bus_owner;
  logic [15:0]      mem_a;
  logic [7:0]       mem_dout;
  logic [7:0]       mem_din;
  logic             mem_mreq_n;
  logic             mem_rd_n;
  logic             mem_wr_n;

  modport master (
    input  start, src_addr, dst_addr, length, cpu_busak_n, mem_din,
    output busy, done, cpu_busrq_n, bus_owner, mem_a, mem_dout,
           mem_mreq_n, mem_rd_n, mem_wr_n
  );

  modport slave (
    output start, src_addr, dst_addr, length, cpu_busak_n, mem_din,
    input  busy, done, cpu_busrq_n, bus_owner, mem_a, mem_dout,
           mem_mreq_n, mem_rd_n, mem_wr_n
  );
endinterface

// File: rtl/z80_dma_arbiter.sv
// Burst-limited memory-to-memory DMA that borrows the Z80 bus via busrq_n/busak_n.
// All bus outputs decode from registered state, so reset releases the bus immediately.
module z80_dma_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  z80_dma_arbiter_if.master  dma
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD_A = 3'd2;
  localparam logic [2:0] S_RD_D = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_REL  = 3'd5;
  localparam logic [2:0] S_GAP  = 3'd6;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

  logic [2:0]       state_q, state_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       burst_q, burst_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             owner_q, owner_d;

  logic in_rd, in_wr;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    burst_d = burst_q;
    data_d  = data_q;
    owner_d = owner_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dma.start) begin
          if (dma.length != '0) begin
            src_d   = dma.src_addr;
            dst_d   = dma.dst_addr;
            rem_d   = dma.length;
            state_d = S_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (!dma.cpu_busak_n) begin
          owner_d = 1'b1;
          burst_d = 8'd0;
          state_d = S_RD_A;
        end
      end
      S_RD_A: state_d = S_RD_D;
      S_RD_D: begin
        data_d  = dma.mem_din;
        src_d   = src_q + 16'd1;
        state_d = S_WR;
      end
      S_WR: begin
        dst_d   = dst_q + 16'd1;
        rem_d   = rem_q - LEN_W'(1);
        burst_d = burst_q + 8'd1;
        // Give the bus back on either the last byte or a full burst.
        if (rem_q == LEN_W'(1) || (burst_q + 8'd1) == BURST_LAST) begin
          owner_d = 1'b0;
          state_d = S_REL;
        end else begin
          state_d = S_RD_A;
        end
      end
      S_REL: begin
        if (dma.cpu_busak_n) begin
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP:   state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      rem_q   <= '0;
      burst_q <= 8'd0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      done_q  <= done_d;
      owner_q <= owner_d;
    end
  end

  assign in_rd = (state_q == S_RD_A) || (state_q == S_RD_D);
  assign in_wr = (state_q == S_WR);

  assign dma.busy        = (state_q != S_IDLE);
  assign dma.done        = done_q;
  assign dma.bus_owner   = owner_q;
  assign dma.cpu_busrq_n = !((state_q == S_REQ) || in_rd || in_wr);
  assign dma.mem_mreq_n  = !(in_rd || in_wr);
  assign dma.mem_rd_n    = !in_rd;
  assign dma.mem_wr_n    = !in_wr;
  assign dma.mem_a       = in_rd ? src_q : (in_wr ? dst_q : 16'h0000);
  assign dma.mem_dout    = in_wr ? data_q : 8'h00;
endmodule

// File: tb/tb_z80_dma_arbiter.sv
// Directed bench: CPU bus-ack model, 64 KiB memory with registered read, bus monitors.
module tb_z80_dma_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  z80_dma_arbiter_if #(.LEN_W(16)) bus ();

  z80_dma_arbiter #(.MAX_BURST(16), .LEN_W(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dma     (bus)
  );

  int checks = 0;
  int passes = 0;

  // Memory model plus host-side preload port
  logic [7:0]  mem [0:65535];
  logic        host_we;
  logic [15:0] host_a;
  logic [7:0]  host_d;

  always @(posedge clk) begin
    bus.cpu_busak_n <= bus.cpu_busrq_n;
    if (host_we) mem[host_a] <= host_d;
    else if (bus.bus_owner && !bus.mem_mreq_n) begin
      if (!bus.mem_rd_n) bus.mem_din <= mem[bus.mem_a];
      if (!bus.mem_wr_n) mem[bus.mem_a] <= bus.mem_dout;
    end
  end

  // Bus monitors
  int req_periods = 0, wr_cnt = 0, owner_cycles = 0, done_cnt = 0, viol = 0;
  int hi_run = 0, cur_bytes = 0, burst_idx = 0, rd_idx = 0;
  int gap_log [0:63];
  int burst_log [0:63];
  logic [15:0] rd_log [0:63];
  logic prev_rq = 1'b1, prev_rd = 1'b1;

  always @(posedge clk) begin
    prev_rq <= bus.cpu_busrq_n;
    prev_rd <= bus.mem_rd_n;
    if (bus.cpu_busrq_n === 1'b1) hi_run <= hi_run + 1;
    if (bus.cpu_busrq_n === 1'b0 && prev_rq === 1'b1) begin
      gap_log[req_periods[5:0]] <= hi_run;
      hi_run <= 0;
      req_periods <= req_periods + 1;
    end
    if (bus.cpu_busrq_n === 1'b1 && prev_rq === 1'b0) begin
      burst_log[burst_idx[5:0]] <= cur_bytes;
      cur_bytes <= 0;
      burst_idx <= burst_idx + 1;
    end
    if (bus.mem_mreq_n === 1'b0 && bus.mem_wr_n === 1'b0) begin
      wr_cnt    <= wr_cnt + 1;
      cur_bytes <= cur_bytes + 1;
    end
    if (bus.mem_mreq_n === 1'b0 && bus.mem_rd_n === 1'b0 && prev_rd === 1'b1) begin
      rd_log[rd_idx[5:0]] <= bus.mem_a;
      rd_idx <= rd_idx + 1;
    end
    if (bus.bus_owner === 1'b1) owner_cycles <= owner_cycles + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.bus_owner !== 1'b1 &&
        (bus.mem_mreq_n !== 1'b1 || bus.mem_rd_n !== 1'b1 || bus.mem_wr_n !== 1'b1))
      viol <= viol + 1;
    if (bus.bus_owner === 1'b1 && bus.cpu_busak_n === 1'b1) viol <= viol + 1;
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_a = a; host_d = d;
    @(posedge clk);
    #1 host_we = 1'b0;
  endtask

  task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.src_addr = s; bus.dst_addr = d; bus.length = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done_cnt != d0) ok = 1'b1;
    end
    checks++;
    if (!ok) $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    else passes++;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    got = {bus.busy, bus.done, bus.bus_owner, bus.cpu_busrq_n, bus.mem_mreq_n,
           bus.mem_rd_n, bus.mem_wr_n, bus.mem_a, bus.mem_dout[0]};
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bus_owner !== 1'b0 ||
        bus.cpu_busrq_n !== 1'b1 || bus.mem_mreq_n !== 1'b1 || bus.mem_rd_n !== 1'b1 ||
        bus.mem_wr_n !== 1'b1)
      $display("FAIL reset_ctrl: got %b required busy0 done0 own0 rq1 mreq1 rd1 wr1", got[31:17]);
    else passes++;
    checks++;
    if (bus.mem_a !== 16'h0000 || bus.mem_dout !== 8'h00)
      $display("FAIL reset_bus: mem_a=%h mem_dout=%h required 0000/00", bus.mem_a, bus.mem_dout);
    else passes++;
  endtask

  task automatic test_single_burst();
    int r0, o0, d0;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) poke(16'h1000 + 16'(i), exp[i]);
    r0 = req_periods; o0 = owner_cycles; d0 = done_cnt;
    kick(16'h1000, 16'h2000, 16'd4);
    checks++;
    if (bus.busy !== 1'b1 || bus.cpu_busrq_n !== 1'b0)
      $display("FAIL single_req: busy=%b busrq_n=%b required 1/0", bus.busy, bus.cpu_busrq_n);
    else passes++;
    wait_done(100, "single");
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL single_done_width: done=%b busy=%b required 0/0", bus.done, bus.busy);
    else passes++;
    checks++;
    if (owner_cycles - o0 != 12)
      $display("FAIL single_clocks: owner cycles %0d required 12", owner_cycles - o0);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h2000 + 16'(i)] !== exp[i])
        $display("FAIL single_data[%0d]: got %h required %h", i, mem[16'h2000 + 16'(i)], exp[i]);
      else passes++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || req_periods - r0 != 1)
      $display("FAIL single_counts: done %0d req periods %0d required 1/1", done_cnt - d0, req_periods - r0);
    else passes++;
  endtask

  task automatic test_zero_length();
    int r0, w0;
    r0 = req_periods; w0 = wr_cnt;
    kick(16'h1000, 16'h2000, 16'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL zero_done: done=%b busy=%b required 1/0", bus.done, bus.busy);
    else passes++;
    repeat (6) @(negedge clk);
    checks++;
    if (req_periods != r0 || wr_cnt != w0 || mem[16'h2000] !== 8'h11)
      $display("FAIL zero_quiet: req %0d writes %0d mem=%h required 0/0/11",
               req_periods - r0, wr_cnt - w0, mem[16'h2000]);
    else passes++;
  endtask

  task automatic test_burst_split();
    int r0, b0, o0, bad;
    for (int i = 0; i < 40; i++) poke(16'h4000 + 16'(i), 8'(i * 7 + 3));
    r0 = req_periods; b0 = burst_idx; o0 = owner_cycles;
    kick(16'h4000, 16'h5000, 16'd40);
    wait_done(600, "split");
    checks++;
    if (req_periods - r0 != 3)
      $display("FAIL split_periods: got %0d required 3", req_periods - r0);
    else passes++;
    checks++;
    if (burst_log[b0] != 16 || burst_log[b0 + 1] != 16 || burst_log[b0 + 2] != 8)
      $display("FAIL split_sizes: got %0d,%0d,%0d required 16,16,8",
               burst_log[b0], burst_log[b0 + 1], burst_log[b0 + 2]);
    else passes++;
    checks++;
    if (gap_log[r0 + 1] != 3 || gap_log[r0 + 2] != 3)
      $display("FAIL split_gap: high cycles %0d,%0d required 3,3", gap_log[r0 + 1], gap_log[r0 + 2]);
    else passes++;
    checks++;
    if (owner_cycles - o0 != 120)
      $display("FAIL split_clocks: owner cycles %0d required 120", owner_cycles - o0);
    else passes++;
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (mem[16'h5000 + 16'(i)] !== 8'(i * 7 + 3)) bad++;
    checks++;
    if (bad != 0) $display("FAIL split_data: %0d bad bytes required 0", bad);
    else passes++;
  endtask

  task automatic test_wrap();
    int r0;
    logic [15:0] ra [4];
    logic [7:0]  dv [4];
    ra = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    dv = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 4; i++) poke(ra[i], dv[i]);
    r0 = rd_idx;
    kick(16'hFFFE, 16'h7FFE, 16'd4);
    wait_done(100, "wrap");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[6'(r0 + i)] !== ra[i] || mem[16'h7FFE + 16'(i)] !== dv[i])
        $display("FAIL wrap[%0d]: read %h wrote %h required %h/%h",
                 i, rd_log[6'(r0 + i)], mem[16'h7FFE + 16'(i)], ra[i], dv[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0, r0;
    bit hit;
    for (int i = 0; i < 8; i++) poke(16'h6000 + 16'(i), 8'h60 + 8'(i));
    poke(16'h6102, 8'hEE);
    w0 = wr_cnt; d0 = done_cnt;
    kick(16'h6000, 16'h6100, 16'd8);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (bus.mem_wr_n === 1'b0 && wr_cnt == w0 + 2) hit = 1'b1;
    end
    checks++;
    if (!hit) $display("FAIL rstmid_reach: byte-3 write not seen required seen");
    else passes++;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.cpu_busrq_n !== 1'b1 || bus.bus_owner !== 1'b0 || bus.mem_mreq_n !== 1'b1 ||
        bus.mem_rd_n !== 1'b1 || bus.mem_wr_n !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL rstmid_release: rq=%b own=%b mreq=%b rd=%b wr=%b busy=%b required 1,0,1,1,1,0",
               bus.cpu_busrq_n, bus.bus_owner, bus.mem_mreq_n, bus.mem_rd_n, bus.mem_wr_n, bus.busy);
    else passes++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    r0 = req_periods;
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt != d0 || mem[16'h6102] !== 8'hEE || bus.cpu_busak_n !== 1'b1 || req_periods != r0)
      $display("FAIL rstmid_after: done %0d mem=%h busak_n=%b req %0d required 0/EE/1/0",
               done_cnt - d0, mem[16'h6102], bus.cpu_busak_n, req_periods - r0);
    else passes++;
  endtask

  task automatic test_start_busy();
    int d0, o0;
    logic [7:0] exp [4];
    exp = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    for (int i = 0; i < 4; i++) poke(16'h7000 + 16'(i), exp[i]);
    poke(16'h7200, 8'hFF);
    poke(16'h7300, 8'h00);
    d0 = done_cnt; o0 = owner_cycles;
    kick(16'h7000, 16'h7100, 16'd4);
    repeat (2) @(negedge clk);
    kick(16'h7200, 16'h7300, 16'd3);
    wait_done(100, "busy");
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || owner_cycles - o0 != 12 || mem[16'h7300] !== 8'h00)
      $display("FAIL busy_ignored: done %0d owner %0d mem7300=%h required 1/12/00",
               done_cnt - d0, owner_cycles - o0, mem[16'h7300]);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h7100 + 16'(i)] !== exp[i])
        $display("FAIL busy_data[%0d]: got %h required %h", i, mem[16'h7100 + 16'(i)], exp[i]);
      else passes++;
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0) $display("FAIL protocol: %0d bus ownership violations required 0", viol);
    else passes++;
  endtask

  initial begin
    reset_n = 1'b0;
    host_we = 1'b0; host_a = 16'h0; host_d = 8'h0;
    bus.start = 1'b0; bus.src_addr = 16'h0; bus.dst_addr = 16'h0; bus.length = 16'h0;
    #2;
    test_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_single_burst();
    test_zero_length();
    test_burst_split();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
